// File: rtl/mtm_alu_deserializer.sv
// Serial front-end of mtm_Alu: decodes 11-bit frames from 'sin' into operands B, A and opcode.
// Checks frame count, CRC4 and opcode, then emits one registered result beat per packet.
module mtm_alu_deserializer #(
    parameter int IDLE_MIN = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_b,
    output logic [31:0] out_a,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err
);

    localparam int IW = $clog2(IDLE_MIN + 2);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MIN);
    localparam logic [TW-1:0] TO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic          r_type;
    logic [7:0]    r_pay;
    logic [63:0]   r_shift;
    logic [3:0]    r_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [2:0]    w_op;
    logic [3:0]    w_crc;
    logic [2:0]    w_ctl_err;
    logic          w_timeout;

    // CRC4 x^4+x+1, init 0, MSB of the message first
    function automatic logic [3:0] crc4_68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = d[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // frame-level state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // next-state: start bit needs enough idle samples since the last stop bit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!sin && (r_idle_cnt >= IDLE_SAT)) w_state_nxt = S_TYPE;
                else                                  w_state_nxt = S_IDLE;
            end
            S_TYPE:    w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                else                   w_state_nxt = S_PAYLOAD;
            end
            S_STOP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ctl-frame verdict in priority order: count, CRC, opcode
    always_comb begin
        w_op  = r_pay[6:4];
        w_crc = crc4_68({r_shift, 1'b1, w_op});
        if (r_cnt != 4'd8)
            w_ctl_err = 3'b100;
        else if (w_crc != r_pay[3:0])
            w_ctl_err = 3'b010;
        else if (!((w_op == 3'b000) || (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b101)))
            w_ctl_err = 3'b001;
        else
            w_ctl_err = 3'b000;
    end

    // stale partial packet: idle line long enough while bytes are pending
    always_comb begin
        if (TIMEOUT != 0)
            w_timeout = (r_state == S_IDLE) && sin && (r_cnt != 4'd0) && (r_to_cnt == TO_LAST);
        else
            w_timeout = 1'b0;
    end

    // frame payload capture, packet assembly and registered result beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_type     <= 1'b0;
            r_pay      <= 8'd0;
            r_shift    <= 64'd0;
            r_cnt      <= 4'd0;
            r_idle_cnt <= IDLE_SAT;
            r_to_cnt   <= '0;
            out_valid  <= 1'b0;
            out_b      <= 32'd0;
            out_a      <= 32'd0;
            out_op     <= 3'd0;
            out_err    <= 3'd0;
        end else begin
            out_valid <= 1'b0;
            if ((r_state == S_IDLE) && sin && (r_cnt != 4'd0) && !w_timeout)
                r_to_cnt <= r_to_cnt + TW'(1);
            else
                r_to_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (!sin)                         r_idle_cnt <= '0;
                    else if (r_idle_cnt != IDLE_SAT)  r_idle_cnt <= r_idle_cnt + IW'(1);
                    if (w_timeout) r_cnt <= 4'd0;
                end
                S_TYPE: begin
                    r_type    <= sin;
                    r_bit_cnt <= 3'd0;
                end
                S_PAYLOAD: begin
                    r_pay     <= {r_pay[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_STOP: begin
                    r_idle_cnt <= '0;
                    if (!sin || r_type) begin
                        out_valid <= 1'b1;
                        out_b     <= r_shift[63:32];
                        out_a     <= r_shift[31:0];
                        out_op    <= w_op;
                        out_err   <= sin ? w_ctl_err : 3'b100;
                        r_cnt     <= 4'd0;
                    end else begin
                        r_shift <= {r_shift[55:0], r_pay};
                        if (r_cnt != 4'd9) r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_bit_cnt <= 3'd0;
            endcase
        end
    end

endmodule
